// File: rtl/cla4_seq_ctrl_if.sv
// Request/result bundle for the nibble-serial adder sequencer.
// The master issues operands with start; the slave returns the result with a done pulse.
interface cla4_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         pg;
  logic         gg;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, pg, gg
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, pg, gg
  );
endinterface

// File: rtl/cla4_seq_ctrl.sv
// Nibble-serial add/subtract sequencer built around one 4-bit carry look-ahead slice.
// Operands are latched on start, one nibble is processed per clock LSB-first.

module cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co,
  output logic       PG,
  output logic       GG
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = Ci;
  assign c[1] = g[0] | (p[0] & Ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);

  assign PG = &p;
  assign GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign Co = GG | (PG & Ci);
  assign S  = p ^ c;
endmodule

module cla4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  cla4_seq_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [KW-1:0]  k_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry_reg;
  logic [W-1:0]   result_reg;
  logic           pg_acc_reg;
  logic           gg_acc_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [W-1:0]   sum_reg;
  logic           cout_reg;
  logic           ovf_reg;
  logic           pg_reg;
  logic           gg_reg;

  logic [3:0]     a_nib [NIBBLES];
  logic [3:0]     b_nib [NIBBLES];
  logic [3:0]     cla_s;
  logic           cla_co;
  logic           cla_pg;
  logic           cla_gg;
  logic [W-1:0]   result_next;
  logic           pg_next;
  logic           gg_next;
  logic           accept;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*4 +: 4];
      assign b_nib[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  cla4 u_cla4 (
    .A  (a_nib[k_reg]),
    .B  (b_nib[k_reg]),
    .Ci (carry_reg),
    .S  (cla_s),
    .Co (cla_co),
    .PG (cla_pg),
    .GG (cla_gg)
  );

  always_comb begin
    result_next = result_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_reg == KW'(i)) begin
        result_next[i*4 +: 4] = cla_s;
      end
    end
  end

  assign pg_next = pg_acc_reg & cla_pg;
  assign gg_next = cla_gg | (cla_pg & gg_acc_reg);

  // The edge leaving DONE is the first idle sampling point, giving one op per NIBBLES+1 cycles.
  assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      pg_acc_reg <= 1'b0;
      gg_acc_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      pg_reg     <= 1'b0;
      gg_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        state_reg  <= RUN;
        busy_reg   <= 1'b1;
        k_reg      <= '0;
        a_reg      <= bus.a;
        b_reg      <= bus.sub ? ~bus.b : bus.b;
        carry_reg  <= bus.sub ? 1'b1 : bus.cin;
        pg_acc_reg <= 1'b1;
        gg_acc_reg <= 1'b0;
      end else begin
        case (state_reg)
          RUN: begin
            result_reg <= result_next;
            carry_reg  <= cla_co;
            pg_acc_reg <= pg_next;
            gg_acc_reg <= gg_next;
            k_reg      <= k_reg + KW'(1);
            if (k_reg == K_LAST) begin
              state_reg <= DONE;
              k_reg     <= '0;
              done_reg  <= 1'b1;
              sum_reg   <= result_next;
              cout_reg  <= cla_co;
              pg_reg    <= pg_next;
              gg_reg    <= gg_next;
              ovf_reg   <= (a_reg[W-1] ~^ b_reg[W-1]) & (result_next[W-1] ^ a_reg[W-1]);
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.pg   = pg_reg;
  assign bus.gg   = gg_reg;
endmodule

// File: doc/cla4_seq_ctrl.md
# cla4_seq_ctrl

Nibble-serial adder/subtractor sequencer that time-multiplexes a single `CLA4` instance (4-bit carry look-ahead adder: `A`, `B`, `Ci` → `S`, `Co`, `PG`, `GG`) to perform one wide add or subtract per request. It latches the operands on a start handshake, feeds one nibble per clock LSB-first, and chains the carry through a register. It accumulates group propagate/generate across nibbles and presents the full result with a one-cycle `done` pulse. It sits between the lab's operand registers and the result bus wherever area matters more than single-cycle latency.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `sub` in 1: 1 = a − b, 0 = a + b + cin. Latched with `start`.
- `a` in W: operand A. Latched with `start`.
- `b` in W: operand B. Latched with `start`.
- `cin` in 1: carry-in for add. Ignored when `sub`=1.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse when the result is valid.
- `sum` out W: result. Held from DONE until the next DONE.
- `cout` out 1: final carry out.
- `ovf` out 1: two's-complement overflow.
- `pg` out 1: whole-word group propagate.
- `gg` out 1: whole-word group generate.

## Operation
- One `CLA4` instance is internal, driven from the operand registers, nibble index k, and the carry register.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1. On that edge latch `a`, set B_eff = `sub` ? ~`b` : `b`, set carry register = `sub` ? 1 : `cin`, k=0, pg_acc=1, gg_acc=0.
  - RUN: each edge does the following, then k++.
    - Capture `S` into result nibble k.
    - carry ← `Co`.
    - pg_acc ← pg_acc & `PG`.
    - gg_acc ← `GG` | (`PG` & gg_acc).
  - RUN → DONE on the edge that processes k = NIBBLES−1.
  - On entry to DONE, publish outputs:
    - `sum` = result register.
    - `cout` = final carry.
    - `pg`/`gg` = accumulators.
    - `ovf` = (a[W−1] ~^ B_eff[W−1]) & (sum[W−1] ^ a[W−1]).
  - DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored; it is neither queued nor restarting.
- Arithmetic is modulo 2^W. For subtract, `cout`=1 means no borrow (a ≥ b unsigned).
- `pg`/`gg` describe the combined B_eff operand. They are independent of carry-in.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, `pg`=0, `gg`=0. State IDLE, k=0.
- Edge T0 samples `start`; `busy`=1 from T0.
- Nibbles are captured at T1..T_NIBBLES.
- `done`=1 for exactly the cycle between T_NIBBLES and T_NIBBLES+1. For NIBBLES=4, that is the 5th cycle after the start cycle.
- `busy`=0 after T_NIBBLES+1. The earliest next accepted `start` is sampled at T_NIBBLES+1.
- Back-to-back throughput: one operation per NIBBLES+1 cycles.
- Operands may change after T0 without affecting the operation in flight.
- Outputs are stable between `done` pulses. They do not glitch during a subsequent RUN.
- `reset` at any edge, including mid-RUN or during DONE, aborts the operation. All outputs and state take reset values on that edge; no `done` is issued.
- `reset` and `start` high together: `reset` wins and `start` is dropped.

## Test plan
- Reset then idle 10 cycles, `start`=0 → all outputs 0 throughout, `done` never pulses.
- `a`=16'h1234, `b`=16'h4321, `cin`=0, `sub`=0 → `done` 5 cycles after the start cycle, `sum`=16'h5555, `cout`=0, `ovf`=0, `pg`=0, `gg`=0. `busy` high exactly 5 cycles.
- `a`=16'hFFFF, `b`=16'h0000, `cin`=1 → `sum`=16'h0000, `cout`=1, `pg`=1, `gg`=0, `ovf`=0. Then `a`=16'hFFFF, `b`=16'h0001, `cin`=0 → `sum`=16'h0000, `cout`=1, `pg`=0, `gg`=1.
- `sub`=1, `a`=16'h8000, `b`=16'h0001 → `sum`=16'h7FFF, `cout`=1, `ovf`=1. Then `sub`=1, `a`=16'h0003, `b`=16'h0005 → `sum`=16'hFFFE, `cout`=0, `ovf`=0.
- `start` with 16'h0001+16'h0001, then `start` held high with different operands during RUN/DONE → single `done`, `sum`=16'h0002. The held `start` is accepted only at the first IDLE edge, giving the next `done` 5 cycles later.
- Assert `reset` on the 2nd RUN edge of an operation → outputs 0, `busy`=0 next cycle, no `done`. A following `start` with 16'h00FF+16'h0001 → `sum`=16'h0100, `cout`=0.
